// File: rtl/lcd_pixel_spi_ctrl.sv
// Register-mapped controller for a 4-wire SPI RGB565 TFT panel: panel reset and
// init command list after reset, then single-pixel CASET/RASET/RAMWR writes.
module lcd_pixel_spi_ctrl #(
    parameter int          ADDRESS_WIDTH = 12,
    parameter logic [15:0] LCD_W_P       = 16'd128,
    parameter logic [15:0] LCD_H_P       = 16'd128,
    parameter int          CLK_DIV       = 1,
    parameter int          RST_CYCLES    = 16,
    parameter int          INIT_WAIT     = 64
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,
    input  logic                     up_wreq,
    input  logic [ADDRESS_WIDTH-1:0] up_waddr,
    input  logic [31:0]              up_wdata,
    output logic                     up_wack,
    input  logic                     up_rreq,
    input  logic [ADDRESS_WIDTH-1:0] up_raddr,
    output logic [31:0]              up_rdata,
    output logic                     up_rack,
    output logic                     lcd_rst_n_out,
    output logic                     lcd_cs_out,
    output logic                     lcd_dc_out,
    output logic                     lcd_clk_out,
    output logic                     lcd_data_out
);

    localparam logic [2:0] ST_RST   = 3'd0;
    localparam logic [2:0] ST_RWAIT = 3'd1;
    localparam logic [2:0] ST_INIT  = 3'd2;
    localparam logic [2:0] ST_IDLE  = 3'd3;
    localparam logic [2:0] ST_PIX   = 3'd4;

    localparam logic [2:0] EN_IDLE  = 3'd0;
    localparam logic [2:0] EN_SETUP = 3'd1;
    localparam logic [2:0] EN_HIGH  = 3'd2;
    localparam logic [2:0] EN_LOW   = 3'd3;
    localparam logic [2:0] EN_TAIL  = 3'd4;
    localparam logic [2:0] EN_GAP   = 3'd5;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(INIT_WAIT - 1);
    localparam logic [3:0]  INIT_LAST = 4'd5;
    localparam logic [3:0]  PIX_LAST  = 4'd12;

    logic [31:0] xy_r;
    logic [15:0] color_r;
    logic [15:0] x_work_r;
    logic [15:0] y_work_r;
    logic [15:0] color_work_r;
    logic        busy_r;
    logic        init_done_r;
    logic        pixel_done_r;
    logic        coord_err_r;
    logic [2:0]  state_r;
    logic [3:0]  idx_r;
    logic [15:0] cnt_r;
    logic        wait_r;
    logic        xfer_r;
    logic        rst_n_r;

    logic [2:0]  eng_r;
    logic [15:0] dcnt_r;
    logic [2:0]  bcnt_r;
    logic [7:0]  sh_r;
    logic        cs_r;
    logic        sclk_r;
    logic        mosi_r;
    logic        dc_r;
    logic        eng_done_r;

    logic        wack_r;
    logic        rack_r;
    logic [31:0] rdata_r;

    logic        wr_acc_s;
    logic        ctrl_wr_s;
    logic        start_s;
    logic        reinit_s;
    logic        coord_bad_s;
    logic        eng_start_s;
    logic [7:0]  seq_byte_s;
    logic        seq_dc_s;
    logic [31:0] rd_mux_s;

    assign wr_acc_s    = up_wreq && !wack_r;
    assign ctrl_wr_s   = wr_acc_s && (up_waddr == ADDRESS_WIDTH'(0));
    assign reinit_s    = ctrl_wr_s && up_wdata[1] && !busy_r;
    assign start_s     = ctrl_wr_s && up_wdata[0] && init_done_r && !busy_r && !reinit_s;
    assign coord_bad_s = (xy_r[31:16] >= LCD_W_P) || (xy_r[15:0] >= LCD_H_P);
    assign eng_start_s = ((state_r == ST_INIT) || (state_r == ST_PIX)) && !xfer_r && !wait_r && !reinit_s;

    // Byte to send for the current position in the init or pixel command list.
    always_comb begin
        seq_byte_s = 8'h00;
        seq_dc_s   = 1'b0;
        if (state_r == ST_INIT) begin
            case (idx_r)
                4'd0:    begin seq_byte_s = 8'h11; seq_dc_s = 1'b0; end
                4'd1:    begin seq_byte_s = 8'h3A; seq_dc_s = 1'b0; end
                4'd2:    begin seq_byte_s = 8'h05; seq_dc_s = 1'b1; end
                4'd3:    begin seq_byte_s = 8'h36; seq_dc_s = 1'b0; end
                4'd4:    begin seq_byte_s = 8'h00; seq_dc_s = 1'b1; end
                4'd5:    begin seq_byte_s = 8'h29; seq_dc_s = 1'b0; end
                default: begin seq_byte_s = 8'h00; seq_dc_s = 1'b0; end
            endcase
        end else begin
            case (idx_r)
                4'd0:        begin seq_byte_s = 8'h2A;               seq_dc_s = 1'b0; end
                4'd1, 4'd3:  begin seq_byte_s = x_work_r[15:8];      seq_dc_s = 1'b1; end
                4'd2, 4'd4:  begin seq_byte_s = x_work_r[7:0];       seq_dc_s = 1'b1; end
                4'd5:        begin seq_byte_s = 8'h2B;               seq_dc_s = 1'b0; end
                4'd6, 4'd8:  begin seq_byte_s = y_work_r[15:8];      seq_dc_s = 1'b1; end
                4'd7, 4'd9:  begin seq_byte_s = y_work_r[7:0];       seq_dc_s = 1'b1; end
                4'd10:       begin seq_byte_s = 8'h2C;               seq_dc_s = 1'b0; end
                4'd11:       begin seq_byte_s = color_work_r[15:8];  seq_dc_s = 1'b1; end
                4'd12:       begin seq_byte_s = color_work_r[7:0];   seq_dc_s = 1'b1; end
                default:     begin seq_byte_s = 8'h00;               seq_dc_s = 1'b0; end
            endcase
        end
    end

    // Read data mux over the register map.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (up_raddr)
            ADDRESS_WIDTH'(1): rd_mux_s = {26'd0, coord_err_r, pixel_done_r, init_done_r, 2'b00, busy_r};
            ADDRESS_WIDTH'(2): rd_mux_s = xy_r;
            ADDRESS_WIDTH'(4): rd_mux_s = {16'h0000, color_r};
            default:           rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Bus handshake and shadow registers.
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            wack_r  <= 1'b0;
            rack_r  <= 1'b0;
            rdata_r <= 32'h0000_0000;
            xy_r    <= 32'h0000_0000;
            color_r <= 16'h0000;
        end else begin
            wack_r <= wr_acc_s;
            rack_r <= up_rreq;
            if (up_rreq) begin
                rdata_r <= rd_mux_s;
            end
            if (wr_acc_s && (up_waddr == ADDRESS_WIDTH'(2))) begin
                xy_r <= up_wdata;
            end
            if (wr_acc_s && (up_waddr == ADDRESS_WIDTH'(4))) begin
                color_r <= up_wdata[15:0];
            end
        end
    end

    // Sequencer: panel reset, init list, pixel window write and status flags.
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            state_r      <= ST_RST;
            idx_r        <= 4'd0;
            cnt_r        <= 16'd0;
            wait_r       <= 1'b0;
            xfer_r       <= 1'b0;
            rst_n_r      <= 1'b0;
            busy_r       <= 1'b0;
            init_done_r  <= 1'b0;
            pixel_done_r <= 1'b0;
            coord_err_r  <= 1'b0;
            x_work_r     <= 16'd0;
            y_work_r     <= 16'd0;
            color_work_r <= 16'd0;
        end else if (reinit_s) begin
            state_r      <= ST_RST;
            idx_r        <= 4'd0;
            cnt_r        <= 16'd0;
            wait_r       <= 1'b0;
            xfer_r       <= 1'b0;
            rst_n_r      <= 1'b0;
            init_done_r  <= 1'b0;
            pixel_done_r <= 1'b0;
        end else begin
            if (start_s) begin
                x_work_r     <= xy_r[31:16];
                y_work_r     <= xy_r[15:0];
                color_work_r <= color_r;
                idx_r        <= 4'd0;
                if (coord_bad_s) begin
                    coord_err_r  <= 1'b1;
                    pixel_done_r <= 1'b1;
                end else begin
                    coord_err_r  <= 1'b0;
                    pixel_done_r <= 1'b0;
                    busy_r       <= 1'b1;
                    state_r      <= ST_PIX;
                end
            end
            case (state_r)
                ST_RST: begin
                    if (cnt_r == RST_LAST) begin
                        cnt_r   <= 16'd0;
                        rst_n_r <= 1'b1;
                        state_r <= ST_RWAIT;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_RWAIT: begin
                    if (cnt_r == WAIT_LAST) begin
                        cnt_r   <= 16'd0;
                        idx_r   <= 4'd0;
                        state_r <= ST_INIT;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_INIT, ST_PIX: begin
                    if (wait_r) begin
                        // Sleep-out settling time after the first init command.
                        if (cnt_r == WAIT_LAST) begin
                            cnt_r  <= 16'd0;
                            wait_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end else if (eng_start_s) begin
                        xfer_r <= 1'b1;
                    end else if (eng_done_r) begin
                        xfer_r <= 1'b0;
                        if ((state_r == ST_INIT) && (idx_r == INIT_LAST)) begin
                            init_done_r <= 1'b1;
                            idx_r       <= 4'd0;
                            state_r     <= ST_IDLE;
                        end else if ((state_r == ST_PIX) && (idx_r == PIX_LAST)) begin
                            busy_r       <= 1'b0;
                            pixel_done_r <= 1'b1;
                            idx_r        <= 4'd0;
                            state_r      <= ST_IDLE;
                        end else begin
                            idx_r  <= idx_r + 4'd1;
                            wait_r <= (state_r == ST_INIT) && (idx_r == 4'd0);
                        end
                    end
                end
                ST_IDLE: begin
                    cnt_r <= 16'd0;
                end
                default: begin
                    state_r <= ST_RST;
                end
            endcase
        end
    end

    // SPI mode-0 byte engine, MSB first, chip select framed per byte.
    always_ff @(posedge up_clk) begin
        if (!up_rstn || reinit_s) begin
            eng_r      <= EN_IDLE;
            dcnt_r     <= 16'd0;
            bcnt_r     <= 3'd0;
            sh_r       <= 8'h00;
            cs_r       <= 1'b1;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            dc_r       <= 1'b0;
            eng_done_r <= 1'b0;
        end else begin
            eng_done_r <= 1'b0;
            case (eng_r)
                EN_IDLE: begin
                    if (eng_start_s) begin
                        cs_r   <= 1'b0;
                        dc_r   <= seq_dc_s;
                        mosi_r <= seq_byte_s[7];
                        sh_r   <= {seq_byte_s[6:0], 1'b0};
                        bcnt_r <= 3'd0;
                        dcnt_r <= 16'd0;
                        eng_r  <= EN_SETUP;
                    end
                end
                EN_SETUP, EN_LOW: begin
                    if (dcnt_r == DIV_LAST) begin
                        dcnt_r <= 16'd0;
                        sclk_r <= 1'b1;
                        eng_r  <= EN_HIGH;
                    end else begin
                        dcnt_r <= dcnt_r + 16'd1;
                    end
                end
                EN_HIGH: begin
                    if (dcnt_r == DIV_LAST) begin
                        dcnt_r <= 16'd0;
                        sclk_r <= 1'b0;
                        if (bcnt_r == 3'd7) begin
                            eng_r <= EN_TAIL;
                        end else begin
                            bcnt_r <= bcnt_r + 3'd1;
                            mosi_r <= sh_r[7];
                            sh_r   <= {sh_r[6:0], 1'b0};
                            eng_r  <= EN_LOW;
                        end
                    end else begin
                        dcnt_r <= dcnt_r + 16'd1;
                    end
                end
                EN_TAIL: begin
                    if (dcnt_r == DIV_LAST) begin
                        dcnt_r <= 16'd0;
                        cs_r   <= 1'b1;
                        mosi_r <= 1'b0;
                        eng_r  <= EN_GAP;
                    end else begin
                        dcnt_r <= dcnt_r + 16'd1;
                    end
                end
                EN_GAP: begin
                    if (dcnt_r == 16'd1) begin
                        dcnt_r     <= 16'd0;
                        eng_done_r <= 1'b1;
                        eng_r      <= EN_IDLE;
                    end else begin
                        dcnt_r <= dcnt_r + 16'd1;
                    end
                end
                default: begin
                    eng_r <= EN_IDLE;
                end
            endcase
        end
    end

    assign up_wack       = wack_r;
    assign up_rack       = rack_r;
    assign up_rdata      = rdata_r;
    assign lcd_rst_n_out = rst_n_r;
    assign lcd_cs_out    = cs_r;
    assign lcd_dc_out    = dc_r;
    assign lcd_clk_out   = sclk_r;
    assign lcd_data_out  = mosi_r;

endmodule

// File: tb/tb_lcd_pixel_spi_ctrl.sv
// Self-checking bench: SPI byte monitor plus a command-list model of the panel
// traffic, driven by directed steps and randomized pixel sweeps.
module tb_lcd_pixel_spi_ctrl;

    logic        up_clk = 1'b0;
    logic        up_rstn;
    logic        up_wreq;
    logic [11:0] up_waddr;
    logic [31:0] up_wdata;
    logic        up_wack;
    logic        up_rreq;
    logic [11:0] up_raddr;
    logic [31:0] up_rdata;
    logic        up_rack;
    logic        lcd_rst_n_out;
    logic        lcd_cs_out;
    logic        lcd_dc_out;
    logic        lcd_clk_out;
    logic        lcd_data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [8:0]  rx_q[$];
    logic [8:0]  exp_q[$];
    int          rx_bits = 0;
    logic [7:0]  rx_sh   = 8'h00;
    logic        rx_dc   = 1'b0;
    logic [31:0] rd;
    logic [31:0] gxy;
    logic [31:0] gcol;

    lcd_pixel_spi_ctrl dut (
        .up_clk        (up_clk),
        .up_rstn       (up_rstn),
        .up_wreq       (up_wreq),
        .up_waddr      (up_waddr),
        .up_wdata      (up_wdata),
        .up_wack       (up_wack),
        .up_rreq       (up_rreq),
        .up_raddr      (up_raddr),
        .up_rdata      (up_rdata),
        .up_rack       (up_rack),
        .lcd_rst_n_out (lcd_rst_n_out),
        .lcd_cs_out    (lcd_cs_out),
        .lcd_dc_out    (lcd_dc_out),
        .lcd_clk_out   (lcd_clk_out),
        .lcd_data_out  (lcd_data_out)
    );

    always #5 up_clk = ~up_clk;

    // Panel-side receiver: shift MOSI on SCLK rise, frame bytes by chip select.
    always @(negedge lcd_cs_out) rx_bits = 0;
    always @(posedge lcd_clk_out) begin
        if (!lcd_cs_out) begin
            rx_sh = {rx_sh[6:0], lcd_data_out};
            rx_dc = lcd_dc_out;
            rx_bits++;
        end
    end
    always @(posedge lcd_cs_out) begin
        if (rx_bits == 8) rx_q.push_back({rx_dc, rx_sh});
        rx_bits = 0;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge up_clk);
        up_wreq = 1'b1; up_waddr = a; up_wdata = d;
        @(posedge up_clk); #1;
        check("wack_pulse", {31'd0, up_wack}, 32'd1);
        @(negedge up_clk);
        up_wreq = 1'b0;
        @(posedge up_clk); #1;
        check("wack_single", {31'd0, up_wack}, 32'd0);
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge up_clk);
        up_rreq = 1'b1; up_raddr = a;
        @(posedge up_clk); #1;
        d = up_rdata;
        check("rack", {31'd0, up_rack}, 32'd1);
        @(negedge up_clk);
        up_rreq = 1'b0;
    endtask

    // Poll STATUS until the given bit is set, bounded.
    task automatic wait_status(input int bitpos, input string tag);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < 1500; k++) begin
            bus_read(12'd1, s);
            if (s[bitpos]) break;
        end
        check(tag, {31'd0, s[bitpos]}, 32'd1);
    endtask

    task automatic push_init();
        exp_q.push_back(9'h011); exp_q.push_back(9'h03A); exp_q.push_back(9'h105);
        exp_q.push_back(9'h036); exp_q.push_back(9'h100); exp_q.push_back(9'h029);
    endtask

    task automatic push_pix(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
        exp_q.push_back({1'b0, 8'h2A});
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b1, x[15:8]}); exp_q.push_back({1'b1, x[7:0]});
        end
        exp_q.push_back({1'b0, 8'h2B});
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b1, y[15:8]}); exp_q.push_back({1'b1, y[7:0]});
        end
        exp_q.push_back({1'b0, 8'h2C});
        exp_q.push_back({1'b1, c[15:8]}); exp_q.push_back({1'b1, c[7:0]});
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check({tag, "_byte"}, {23'd0, rx_q[k]}, {23'd0, exp_q[k]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {25'd0, up_wack, up_rack, lcd_rst_n_out, lcd_cs_out, lcd_dc_out, lcd_clk_out, lcd_data_out},
              {25'd0, 7'b0001000});
        check({tag, "_rdata"}, up_rdata, 32'd0);
    endtask

    task automatic release_and_init(input string tag);
        int n;
        @(negedge up_clk);
        up_rstn = 1'b1;
        n = 0;
        do begin
            @(posedge up_clk); #1;
            n++;
        end while (!lcd_rst_n_out && n < 100);
        check({tag, "_rst_low_cycles"}, 32'(n), 32'd16);
        bus_read(12'd1, rd);
        check({tag, "_init_done_early"}, {31'd0, rd[3]}, 32'd0);
        wait_status(3, {tag, "_init_done"});
        push_init();
        compare_stream({tag, "_init"});
    endtask

    initial begin
        logic [15:0] y0;
        logic [15:0] c0;
        logic [15:0] px;
        logic [15:0] py;
        logic [15:0] pc;
        up_rstn = 1'b0; up_wreq = 1'b0; up_waddr = 12'd0; up_wdata = 32'd0;
        up_rreq = 1'b0; up_raddr = 12'd0;
        repeat (3) @(posedge up_clk);
        #1;
        check_reset_outputs("reset_values");
        release_and_init("boot");

        // First pixel with the example coordinates.
        bus_write(12'd2, 32'h0005_0007);
        bus_write(12'd4, 32'h0000_1234);
        bus_write(12'd0, 32'h0000_0001);
        bus_read(12'd1, rd);
        check("status_busy", rd, 32'h0000_0009);
        wait_status(4, "pix1_done");
        bus_read(12'd1, rd);
        check("status_after_pix1", rd, 32'h0000_0018);
        push_pix(16'd5, 16'd7, 16'h1234);
        compare_stream("pix1");

        // Held write request: accepted every second cycle, second start ignored.
        bus_write(12'd2, 32'h0001_0002);
        @(negedge up_clk);
        up_wreq = 1'b1; up_waddr = 12'd0; up_wdata = 32'd1;
        for (int k = 0; k < 4; k++) begin
            @(posedge up_clk); #1;
            check("held_wack", {31'd0, up_wack}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge up_clk);
        up_wreq = 1'b0;
        wait_status(4, "held_done");
        push_pix(16'd1, 16'd2, 16'h1234);
        compare_stream("held");

        // Out-of-range coordinates on each axis.
        bus_write(12'd2, 32'h0080_0000);
        bus_write(12'd0, 32'h0000_0001);
        repeat (40) @(posedge up_clk);
        bus_read(12'd1, rd);
        check("coord_err_x", rd, 32'h0000_0038);
        compare_stream("coord_x");
        bus_write(12'd2, 32'h007F_0080);
        bus_write(12'd0, 32'h0000_0001);
        repeat (40) @(posedge up_clk);
        bus_read(12'd1, rd);
        check("coord_err_y", rd, 32'h0000_0038);
        compare_stream("coord_y");

        // Sweep x across the panel with wrapping y and incrementing colour;
        // shadow registers are overwritten while each pixel is in flight.
        y0 = 16'($urandom_range(0, 127));
        c0 = 16'($urandom);
        for (int i = 0; i < 128; i++) begin
            px = 16'(i);
            py = 16'((y0 + 16'(i)) % 16'd128);
            pc = c0 + 16'(i);
            bus_write(12'd2, {px, py});
            bus_write(12'd4, {16'($urandom), pc});
            bus_write(12'd0, 32'h0000_0001);
            gxy  = $urandom;
            gcol = $urandom;
            bus_write(12'd2, gxy);
            bus_write(12'd4, gcol);
            wait_status(4, "sweep_done");
            push_pix(px, py, pc);
            compare_stream("sweep");
            if (i % 32 == 0) begin
                bus_read(12'd2, rd);
                check("rb_xy", rd, gxy);
                bus_read(12'd4, rd);
                check("rb_color", rd, {16'd0, gcol[15:0]});
                bus_read(12'd3, rd);
                check("rb_addr3", rd, 32'd0);
                bus_read(12'd0, rd);
                check("rb_ctrl", rd, 32'd0);
            end
        end

        // Software re-init restarts the command list.
        bus_write(12'd0, 32'h0000_0002);
        bus_read(12'd1, rd);
        check("reinit_status", rd, 32'h0000_0000);
        wait_status(3, "reinit_done");
        push_init();
        compare_stream("reinit");

        // Hardware reset in the middle of a pixel.
        bus_write(12'd2, 32'h0010_0020);
        bus_write(12'd0, 32'h0000_0001);
        bus_read(12'd1, rd);
        repeat (50) @(posedge up_clk);
        @(negedge up_clk);
        up_rstn = 1'b0;
        @(posedge up_clk); #1;
        check_reset_outputs("midpix_reset");
        repeat (2) @(posedge up_clk);
        #1;
        rx_q.delete();
        release_and_init("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
